mux4_to_1: RTL and testbench
============================

// Module: mux4_to_1
// PURPOSE
//   4-input, WIDTH-bit word selector with a registered output. Used in the datapath
//   wherever one of four 32-bit operands is chosen by a 2-bit control field,
//   e.g. ALU operand or writeback source.
//   Selected word appears on Result one clock after Selector/R0..R3 are sampled.
// PARAMETERS
//   WIDTH         32  data width of R0..R3 and Result
//   REGISTER_OUT  1   1: Result is a flop (1-cycle latency); 0: purely combinational, clk/rst_n unused
// PORTS
//   clk       in   1      system clock; all state changes on the rising edge
//   rst_n     in   1      reset, asynchronous assert, active low
//   Selector  in   2      word select: 00->R0, 01->R1, 10->R2, 11->R3
//   R0        in   WIDTH  candidate word 0
//   R1        in   WIDTH  candidate word 1
//   R2        in   WIDTH  candidate word 2
//   R3        in   WIDTH  candidate word 3
//   Result    out  WIDTH  selected word
// BEHAVIOUR
//   - One clock domain. Reset is asynchronous and active-low.
//   - Reset (rst_n=0, REGISTER_OUT=1): Result = 0 immediately, independent of clk.
//     Result holds 0 while rst_n stays low.
//   - Release: the first rising edge with rst_n=1 loads the selected word.
//   - Each rising edge with rst_n=1: Result <= R[Selector], a full WIDTH-bit copy.
//     No enable; the register updates every cycle.
//   - Latency: exactly 1 cycle from Selector/Rn change to Result. A change of a
//     non-selected input never affects Result.
//   - Simultaneous change of Selector and the newly selected Rn in the same cycle:
//     the new value of that Rn is loaded.
//   - Selector containing X/Z (simulation only): the next Result is all zeros.
//     There is no X propagation from the select.
//   - REGISTER_OUT=0: Result = R[Selector] combinationally, with the same X rule.
//     Reset has no effect in this mode.
//   - Selector never goes out of range; all 4 codes are valid.
//   - No handshake. No state machine beyond the output register.
// STRUCTURE
//   - Shared package: localparams SEL_R0=2'd0, SEL_R1=2'd1, SEL_R2=2'd2, SEL_R3=2'd3.
//     The package also holds the default datapath WIDTH=32.
//   - Sub-module mux4_comb: combinational case-select core, parameterised by WIDTH.
//     mux4_to_1 wraps mux4_comb with a generate-selected output register.
// TESTING  (R0=DEADBEEF, R1=CAFEBABE, R2=0BADF00D, R3=01234567)
//   1. Assert rst_n=0 with Selector=01 -> Result=00000000 with no clock edge.
//      Result stays 0 until rst_n is released and a clock edge occurs.
//   2. Release rst_n, Selector stepped 00,01,10,11,00, each held 10 cycles.
//      Result one edge later: DEADBEEF, CAFEBABE, 0BADF00D, 01234567, DEADBEEF.
//   3. Selector=10 held, R0/R1/R3 toggled every cycle -> Result stays 0BADF00D.
//   4. Selector 00->11 and R3->FFFFFFFF on the same edge -> next Result=FFFFFFFF.
//      Result is never 01234567 in this case.
//   5. Assert rst_n low mid-stream, between edges -> Result=0 at once.
//      After release, the first edge restores R[Selector].
//   6. REGISTER_OUT=0 build, Selector=11 -> Result=01234567 in the same delta.
//      Set Selector=2'bx -> Result=00000000.

Source files
------------

// File: rtl/mux4_to_1_pkg.sv
// -----------------------------------------------------------------------------
// mux4_to_1_pkg
//   Shared constants for the 4-way word selector: the select codes used on the
//   2-bit Selector field and the default datapath width.
// -----------------------------------------------------------------------------
package mux4_to_1_pkg;

  localparam int DATAPATH_WIDTH = 32;

  localparam logic [1:0] SEL_R0 = 2'd0;
  localparam logic [1:0] SEL_R1 = 2'd1;
  localparam logic [1:0] SEL_R2 = 2'd2;
  localparam logic [1:0] SEL_R3 = 2'd3;

endpackage : mux4_to_1_pkg

// File: rtl/mux4_comb.sv
// -----------------------------------------------------------------------------
// mux4_comb
//   Purely combinational 4:1 word select core.
// Ports
//   sel  in  2      word select (SEL_R0..SEL_R3)
//   r0   in  WIDTH  candidate word 0
//   r1   in  WIDTH  candidate word 1
//   r2   in  WIDTH  candidate word 2
//   r3   in  WIDTH  candidate word 3
//   y    out WIDTH  selected word
// -----------------------------------------------------------------------------
module mux4_comb
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = DATAPATH_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] y
);

  // An X/Z select matches none of the explicit codes in simulation and falls
  // through to the default, so the output goes to zero instead of X.
  always_comb begin
    y = '0;
    case (sel)
      SEL_R0:  y = r0;
      SEL_R1:  y = r1;
      SEL_R2:  y = r2;
      SEL_R3:  y = r3;
      default: y = '0;
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux4_to_1.sv
// -----------------------------------------------------------------------------
// mux4_to_1
//   4-input WIDTH-bit word selector, used to pick ALU operands or a writeback
//   source from a 2-bit control field. With REGISTER_OUT=1 the selected word
//   is flopped (one cycle latency, asynchronous active-low clear); with
//   REGISTER_OUT=0 the select is purely combinational and clk/rst_n are unused.
// Ports
//   clk       in  1      system clock, rising edge
//   rst_n     in  1      asynchronous active-low reset (clears Result)
//   Selector  in  2      00->R0, 01->R1, 10->R2, 11->R3
//   R0..R3    in  WIDTH  candidate words
//   Result    out WIDTH  selected word
// -----------------------------------------------------------------------------
module mux4_to_1
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH        = DATAPATH_WIDTH,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Selector,
  input  logic [WIDTH-1:0] R0,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] Result
);

  logic [WIDTH-1:0] sel_word_p0;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_core (
    .sel (Selector),
    .r0  (R0),
    .r1  (R1),
    .r2  (R2),
    .r3  (R3),
    .y   (sel_word_p0)
  );

  // ---- stage p0 -> p1: output register ----
  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH-1:0] result_p1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        result_p1 <= '0;
      end else begin
        result_p1 <= sel_word_p0;
      end
    end

    assign Result = result_p1;
  end else begin : g_comb
    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign Result = sel_word_p0;
  end

endmodule : mux4_to_1

// File: tb/tb_mux4_to_1.sv
module tb_mux4_to_1;

  localparam logic [31:0] W0 = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'hCAFEBABE;
  localparam logic [31:0] W2 = 32'h0BADF00D;
  localparam logic [31:0] W3 = 32'h01234567;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [1:0]  sel_c;
  logic [31:0] r0, r1, r2, r3;
  logic [31:0] result;
  logic [31:0] result_c;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] r0, r1, r2, r3;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  mux4_to_1 #(.WIDTH(32), .REGISTER_OUT(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Selector (sel),
    .R0       (r0),
    .R1       (r1),
    .R2       (r2),
    .R3       (r3),
    .Result   (result)
  );

  mux4_to_1 #(.WIDTH(32), .REGISTER_OUT(1'b0)) dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .Selector (sel_c),
    .R0       (r0),
    .R1       (r1),
    .R2       (r2),
    .R3       (r3),
    .Result   (result_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] e, input int h);
    vec_t v;
    v.name = name; v.sel = s;
    v.r0 = a; v.r1 = b; v.r2 = c; v.r3 = d;
    v.exp = e; v.hold = h;
    vecs.push_back(v);
  endtask

  initial begin
    // selector sweep, each code held 10 cycles
    add_vec("sweep_00", 2'b00, W0, W1, W2, W3, W0, 10);
    add_vec("sweep_01", 2'b01, W0, W1, W2, W3, W1, 10);
    add_vec("sweep_10", 2'b10, W0, W1, W2, W3, W2, 10);
    add_vec("sweep_11", 2'b11, W0, W1, W2, W3, W3, 10);
    add_vec("sweep_00b", 2'b00, W0, W1, W2, W3, W0, 10);
    // non-selected inputs toggling under Selector=10
    add_vec("hold_r2_a", 2'b10, ~W0, ~W1, W2, ~W3, W2, 1);
    add_vec("hold_r2_b", 2'b10,  W0,  W1, W2,  W3, W2, 1);
    add_vec("hold_r2_c", 2'b10, 32'h0, 32'hFFFFFFFF, W2, 32'h5A5A5A5A, W2, 1);
    add_vec("hold_r2_d", 2'b10, 32'hFFFFFFFF, 32'h0, W2, 32'hA5A5A5A5, W2, 1);
    add_vec("hold_r2_e", 2'b10, W3, W0, W2, W1, W2, 1);
    // distinct pattern per input
    add_vec("pat_01", 2'b01, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h22222222, 1);
    add_vec("pat_11", 2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h44444444, 1);

    r0 = W0; r1 = W1; r2 = W2; r3 = W3;
    sel_c = 2'b00;

    // Reset asserted before any clock edge
    sel = 2'b01;
    rst_n = 1'b0;
    #2;
    check("reset_async", result, 32'h0);
    edge_sample();
    check("reset_hold_e1", result, 32'h0);
    edge_sample();
    check("reset_hold_e2", result, 32'h0);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", result, 32'h0);
    edge_sample();
    check("release_first_edge", result, W1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      r0 = vecs[i].r0; r1 = vecs[i].r1; r2 = vecs[i].r2; r3 = vecs[i].r3;
      for (int c = 0; c < vecs[i].hold; c++) begin
        edge_sample();
        check(vecs[i].name, result, vecs[i].exp);
      end
    end

    // Selector and newly selected word change together
    r0 = W0; r1 = W1; r2 = W2; r3 = W3;
    sel = 2'b00;
    edge_sample();
    check("simul_pre", result, W0);
    sel = 2'b11;
    r3 = 32'hFFFFFFFF;
    edge_sample();
    check("simul_new_r3", result, 32'hFFFFFFFF);
    edge_sample();
    check("simul_steady", result, 32'hFFFFFFFF);
    r3 = W3;

    // Reset mid-stream, between edges
    sel = 2'b01;
    edge_sample();
    check("mid_pre", result, W1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", result, 32'h0);
    edge_sample();
    check("mid_reset_hold", result, 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_release_no_edge", result, 32'h0);
    edge_sample();
    check("mid_release_edge", result, W1);

    // Combinational build
    sel_c = 2'b11;
    #1;
    check("comb_sel11", result_c, W3);
    sel_c = 2'b10;
    #1;
    check("comb_sel10", result_c, W2);
    rst_n = 1'b0;
    sel_c = 2'b01;
    #1;
    check("comb_ignores_reset", result_c, W1);
    rst_n = 1'b1;
    r0 = 32'h0;
    sel_c = 2'bxx;
    #1;
    check("comb_sel_x", result_c, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mux4_to_1
